// File: rtl/shift_ctr_pkg.sv
// Shared encodings for the shift counter sequencer: command opcodes,
// counter mode/direction selects and FSM state encoding.
package shift_ctr_pkg;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shift_ctr_core.sv
// Counter datapath: holds the WIDTH-bit ring/Johnson register and applies
// either a parallel load or a single shift step per clock. Load has
// priority over step so a CLEAR issued mid-run cannot be overtaken.
module shift_ctr_core
  import shift_ctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             step,
  input  logic             mode,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_out;

  // Ring rotates the edge bit back in; Johnson feeds back its complement.
  function automatic logic [WIDTH-1:0] step_pattern(input logic [WIDTH-1:0] v,
                                                    input logic             m,
                                                    input logic             d);
    logic [WIDTH-1:0] r;
    if (d == DIR_LEFT) begin
      r = {v[WIDTH-2:0], (m == MODE_JOHNSON) ? ~v[WIDTH-1] : v[WIDTH-1]};
    end else begin
      r = {(m == MODE_JOHNSON) ? ~v[0] : v[0], v[WIDTH-1:1]};
    end
    return r;
  endfunction

  // Counter register: load wins over step, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
    end else if (load) begin
      r_out <= load_data;
    end else if (step) begin
      r_out <= step_pattern(r_out, mode, dir);
    end
  end

  assign out = r_out;

endmodule

// File: rtl/shift_ctr_sequencer.sv
// Command sequencer for a ring/Johnson shift counter. Accepts RUN/LOAD/
// STOP/CLEAR over valid/ready, steps the counter a programmed number of
// times (or free-runs when the count is zero) and reports busy plus
// registered done/wrap/err pulses.
module shift_ctr_sequencer
  import shift_ctr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_mode,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_mode;
  logic             r_dir;
  logic [WIDTH-1:0] r_start_pat;
  logic             r_done;
  logic             r_wrap;
  logic             r_err;

  logic             w_accept;
  logic             w_is_run;
  logic             w_is_load;
  logic             w_is_stop;
  logic             w_is_clear;
  logic             w_load;
  logic [WIDTH-1:0] w_load_data;
  logic             w_step;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_out;

  // Same step rule as the core; used to predict the post-step value so
  // wrap can be registered together with the step itself.
  function automatic logic [WIDTH-1:0] step_pattern(input logic [WIDTH-1:0] v,
                                                    input logic             m,
                                                    input logic             d);
    logic [WIDTH-1:0] r;
    if (d == DIR_LEFT) begin
      r = {v[WIDTH-2:0], (m == MODE_JOHNSON) ? ~v[WIDTH-1] : v[WIDTH-1]};
    end else begin
      r = {(m == MODE_JOHNSON) ? ~v[0] : v[0], v[WIDTH-1:1]};
    end
    return r;
  endfunction

  // DONE is the only state that refuses commands; reset also blocks them.
  assign cmd_ready  = !reset && (r_state != ST_DONE);
  assign busy       = (r_state == ST_RUN);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_is_run   = w_accept && (cmd_op == OP_RUN);
  assign w_is_load  = w_accept && (cmd_op == OP_LOAD);
  assign w_is_stop  = w_accept && (cmd_op == OP_STOP);
  assign w_is_clear = w_accept && (cmd_op == OP_CLEAR);
  assign w_next     = step_pattern(w_out, r_mode, r_dir);

  // Datapath control: CLEAR beats everything, STOP suppresses the step.
  always_comb begin
    w_load      = 1'b0;
    w_load_data = cmd_data;
    w_step      = 1'b0;
    if (w_is_clear) begin
      w_load      = 1'b1;
      w_load_data = '0;
    end else if ((r_state == ST_IDLE) && w_is_load) begin
      w_load = 1'b1;
    end else if ((r_state == ST_RUN) && !w_is_stop) begin
      w_step = 1'b1;
    end
  end

  shift_ctr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .load_data (w_load_data),
    .step      (w_step),
    .mode      (r_mode),
    .dir       (r_dir),
    .out       (w_out)
  );

  // Run parameters are pure data, captured when a RUN is accepted in IDLE.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && w_is_run) begin
      r_start_pat <= w_out;
      r_mode      <= cmd_mode;
      r_dir       <= cmd_dir;
    end
  end

  // Sequencer FSM, remaining-step counter and one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_wrap <= w_step && (w_next == r_start_pat);
      case (r_state)
        ST_IDLE: begin
          if (w_is_run) begin
            r_remaining <= cmd_steps;
            r_state     <= ST_RUN;
          end else if (w_is_stop) begin
            r_err <= 1'b1;
          end else if (w_is_clear) begin
            r_remaining <= '0;
          end
        end
        ST_RUN: begin
          if (w_is_stop) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else if (w_is_clear) begin
            r_remaining <= '0;
            r_state     <= ST_IDLE;
          end else begin
            // RUN/LOAD while running are flagged but do not disturb the run.
            if (w_is_run || w_is_load) begin
              r_err <= 1'b1;
            end
            // A zero count at this point means free-run until STOP.
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - CNT_ONE;
              if (r_remaining == CNT_ONE) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out  = w_out;
  assign done = r_done;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule
